paddle_ctrl: RTL

Parametrised paddle position controller for the pong field. It is the successor to the single-step player state block. It converts raw left/right buttons into a paddle span of SIZE cells on a FIELD_W-cell row. Features:
- synchronised inputs
- one step per press
- auto-repeat while held
- clamped edges
- enable/reload

Sits between the button pins and the ball/collision and display logic.

---
 rtl/pong_pkg.sv | 30 +++
 rtl/btn_sync.sv | 29 ++
 rtl/paddle_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared types and default field geometry for the pong paddle blocks.
package pong_pkg;

    localparam int FIELD_W_DEF = 8;
    localparam int SIZE_DEF    = 2;

    typedef enum logic [1:0] {
        DIR_NONE  = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_RIGHT = 2'd2,
        DIR_BOTH  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_REPEAT,
        ST_LOCK
    } paddle_state_t;

    function automatic dir_t decode_dir(input logic left, input logic right);
        case ({right, left})
            2'b01:   return DIR_LEFT;
            2'b10:   return DIR_RIGHT;
            2'b11:   return DIR_BOTH;
            default: return DIR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchroniser for a left/right button pair plus direction decode.
// One instance per player.
module btn_sync
    import pong_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic btn_left,
    input  logic btn_right,
    output dir_t dir
);

    // bit 0 = left, bit 1 = right
    logic [1:0] meta;
    logic [1:0] sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 2'b00;
            sync <= 2'b00;
        end else begin
            meta <= {btn_right, btn_left};
            sync <= meta;
        end
    end

    assign dir = decode_dir(sync[0], sync[1]);

endmodule

// File: rtl/paddle_ctrl.sv
// Paddle position controller: press steps, optional auto-repeat, edge clamp, enable reload.
// Auto-repeat is built only when PADDLE_AUTOREPEAT_EN is defined; otherwise one step per press.
//
// state  | meaning
// IDLE   | no direction held, next single direction is a press
// HOLD   | first step taken, waiting HOLD_CYC before auto-repeat
// REPEAT | stepping every RPT_CYC while the direction stays held
// LOCK   | no movement until both buttons are released
module paddle_ctrl
    import pong_pkg::*;
#(
    parameter int FIELD_W  = FIELD_W_DEF,
    parameter int SIZE     = SIZE_DEF,
    parameter int START    = 3,
    parameter int HOLD_CYC = 16,
    parameter int RPT_CYC  = 4,
    parameter int POS_W    = $clog2(FIELD_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             btn_left,
    input  logic             btn_right,
    output logic [POS_W-1:0] pos_left,
    output logic [POS_W-1:0] pos_right,
    output logic             step_pulse,
    output logic             at_min,
    output logic             at_max
);

    localparam logic [POS_W-1:0] START_P = POS_W'(START);
    localparam logic [POS_W-1:0] LAST_L  = POS_W'(FIELD_W - SIZE);
    localparam logic [POS_W-1:0] OFFS    = POS_W'(SIZE - 1);
    localparam logic [POS_W-1:0] MAX_R   = POS_W'(FIELD_W - 1);

    dir_t             dir;
    paddle_state_t    state;
    logic [1:0]       settle;
    logic             pend;
    logic             step_ok;
    logic             fire;
    logic [POS_W-1:0] step_pos;

`ifdef PADDLE_AUTOREPEAT_EN
    localparam int CNT_W = $clog2(HOLD_CYC > RPT_CYC ? HOLD_CYC : RPT_CYC);
    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] RPT_LD  = CNT_W'(RPT_CYC - 1);
    logic [CNT_W-1:0] cnt;
    dir_t             dir_q;
`else
    logic unused_timing;
    assign unused_timing = ^{HOLD_CYC[0], RPT_CYC[0]};
`endif

    btn_sync u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .dir       (dir)
    );

    // Every step moves in the currently decoded direction; clamp at the row edges.
    always_comb begin
        step_ok  = 1'b0;
        step_pos = pos_left;
        if (dir == DIR_LEFT && pos_left != '0) begin
            step_ok  = 1'b1;
            step_pos = pos_left - POS_W'(1);
        end else if (dir == DIR_RIGHT && pos_left != LAST_L) begin
            step_ok  = 1'b1;
            step_pos = pos_left + POS_W'(1);
        end
    end

    always_comb begin
        fire = 1'b0;
        if (en && settle[1] && !pend) begin
            case (state)
                ST_IDLE:   fire = (dir == DIR_LEFT) || (dir == DIR_RIGHT);
`ifdef PADDLE_AUTOREPEAT_EN
                ST_HOLD,
                ST_REPEAT: fire = ((dir == DIR_LEFT) || (dir == DIR_RIGHT)) &&
                                  ((dir != dir_q) || (cnt == '0));
`endif
                default:   fire = 1'b0;
            endcase
        end
    end

    // pend marks "first look at the buttons after reset or disable": a held button is not a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            pos_left   <= START_P;
            step_pulse <= 1'b0;
            pend       <= 1'b1;
            settle     <= 2'b00;
`ifdef PADDLE_AUTOREPEAT_EN
            cnt        <= '0;
            dir_q      <= DIR_NONE;
`endif
        end else begin
            settle     <= {settle[0], 1'b1};
            step_pulse <= fire && step_ok;
            if (fire && step_ok)
                pos_left <= step_pos;

            if (!en || !settle[1]) begin
                if (!en)
                    pos_left <= START_P;
                state <= ST_IDLE;
                pend  <= 1'b1;
`ifdef PADDLE_AUTOREPEAT_EN
                cnt   <= '0;
`endif
            end else if (pend) begin
                pend  <= 1'b0;
                state <= (dir == DIR_NONE) ? ST_IDLE : ST_LOCK;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (dir == DIR_LEFT || dir == DIR_RIGHT) begin
`ifdef PADDLE_AUTOREPEAT_EN
                            dir_q <= dir;
                            cnt   <= HOLD_LD;
                            state <= ST_HOLD;
`else
                            state <= ST_LOCK;
`endif
                        end else if (dir == DIR_BOTH) begin
                            state <= ST_LOCK;
                        end
                    end
`ifdef PADDLE_AUTOREPEAT_EN
                    ST_HOLD, ST_REPEAT: begin
                        if (dir == DIR_NONE) begin
                            state <= ST_IDLE;
                        end else if (dir == DIR_BOTH) begin
                            state <= ST_LOCK;
                        end else if (dir != dir_q) begin
                            dir_q <= dir;
                            cnt   <= HOLD_LD;
                            state <= ST_HOLD;
                        end else if (cnt == '0) begin
                            cnt   <= RPT_LD;
                            state <= ST_REPEAT;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
`endif
                    ST_LOCK: begin
                        if (dir == DIR_NONE)
                            state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign pos_right = pos_left + OFFS;
    assign at_min    = (pos_left == '0);
    assign at_max    = (pos_right == MAX_R);

endmodule
